// File: rtl/seq_pkg.sv
// Shared opcode constants, state encoding and decoded-control struct for the sequencer.
package seq_pkg;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_STA = 4'h4;
   localparam logic [3:0] OP_LDI = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JC  = 4'h7;
   localparam logic [3:0] OP_JZ  = 4'h8;
   localparam logic [3:0] OP_IN  = 4'h9;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   // T0..T4 are consecutive so the step counter can simply increment.
   localparam logic [2:0] ST_INIT = 3'd0;
   localparam logic [2:0] ST_T0   = 3'd1;
   localparam logic [2:0] ST_T1   = 3'd2;
   localparam logic [2:0] ST_T2   = 3'd3;
   localparam logic [2:0] ST_T3   = 3'd4;
   localparam logic [2:0] ST_T4   = 3'd5;
   localparam logic [2:0] ST_HALT = 3'd6;

   // All fields active-high; the top inverts the active-low bus selects.
   typedef struct packed {
      logic clr;
      logic ce;
      logic su;
      logic ai;
      logic bi;
      logic oi;
      logic ii;
      logic fi;
      logic mi;
      logic ri;
      logic j;
      logic aout;
      logic bout;
      logic iout;
      logic cout;
      logic eout;
      logic rout;
      logic nout;
      logic hlt;
   } ctrl_t;

   function automatic logic [2:0] last_step(input logic [3:0] op);
      case (op)
         OP_LDA, OP_STA: last_step = ST_T3;
         OP_ADD, OP_SUB: last_step = ST_T4;
         default:        last_step = ST_T2;
      endcase
   endfunction

endpackage

// File: rtl/seq_if.sv
// Sequencer <-> datapath control bundle: master is the sequencer, slave the datapath.
interface seq_if;
   logic       RUN;
   logic [3:0] OPCODE;
   logic       CF, ZF;
   logic       CLR;
   logic       CE, SU, AIn, BIn, OIn, IIn, FIn, MIn, RI;
   logic       Jn, DOn, AOn, BOn, IOn, COn, EOn, ROn, NOn;
   logic       HLT;

   modport master (
      input  RUN, OPCODE, CF, ZF,
      output CLR, CE, SU, AIn, BIn, OIn, IIn, FIn, MIn, RI,
      output Jn, DOn, AOn, BOn, IOn, COn, EOn, ROn, NOn, HLT
   );

   modport slave (
      output RUN, OPCODE, CF, ZF,
      input  CLR, CE, SU, AIn, BIn, OIn, IIn, FIn, MIn, RI,
      input  Jn, DOn, AOn, BOn, IOn, COn, EOn, ROn, NOn, HLT
   );
endinterface

// File: rtl/seq_decode.sv
// Combinational microcode table: (state, opcode, flags, run) -> active-high controls.
module seq_decode
   import seq_pkg::*;
(
   input  logic [2:0] state,
   input  logic [3:0] opcode,
   input  logic       cf,
   input  logic       zf,
   input  logic       run,
   output ctrl_t      ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         ST_INIT: ctrl.clr = 1'b1;
         ST_HALT: ctrl.hlt = 1'b1;
         ST_T0: if (run) begin
            ctrl.cout = 1'b1;
            ctrl.mi   = 1'b1;
         end
         ST_T1: if (run) begin
            ctrl.rout = 1'b1;
            ctrl.ii   = 1'b1;
            ctrl.ce   = 1'b1;
         end
         ST_T2: if (run) begin
            case (opcode)
               OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                  ctrl.iout = 1'b1;
                  ctrl.mi   = 1'b1;
               end
               OP_LDI: begin
                  ctrl.iout = 1'b1;
                  ctrl.ai   = 1'b1;
               end
               OP_JMP: begin
                  ctrl.iout = 1'b1;
                  ctrl.j    = 1'b1;
               end
               // Conditional jumps still drive the operand; only the load is gated.
               OP_JC: begin
                  ctrl.iout = 1'b1;
                  ctrl.j    = cf;
               end
               OP_JZ: begin
                  ctrl.iout = 1'b1;
                  ctrl.j    = zf;
               end
               OP_IN: begin
                  ctrl.nout = 1'b1;
                  ctrl.ai   = 1'b1;
               end
               OP_OUT: begin
                  ctrl.aout = 1'b1;
                  ctrl.oi   = 1'b1;
               end
               default: ;
            endcase
         end
         ST_T3: if (run) begin
            case (opcode)
               OP_LDA: begin
                  ctrl.rout = 1'b1;
                  ctrl.ai   = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  ctrl.rout = 1'b1;
                  ctrl.bi   = 1'b1;
               end
               OP_STA: begin
                  ctrl.aout = 1'b1;
                  ctrl.ri   = 1'b1;
               end
               default: ;
            endcase
         end
         ST_T4: if (run && (opcode == OP_ADD || opcode == OP_SUB)) begin
            ctrl.eout = 1'b1;
            ctrl.ai   = 1'b1;
            ctrl.fi   = 1'b1;
            ctrl.su   = (opcode == OP_SUB);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/sequencer.sv
// Instruction step sequencer: state register + next-state; microcode lives in seq_decode.
// Define SEQ_EARLY_END_EN to return to T0 right after an instruction's last active step.
module sequencer
   import seq_pkg::*;
(
   input  logic CLK,
   input  logic RESETn,
   seq_if.master bus
);

   logic [2:0] state, state_nxt;
   ctrl_t      ctrl;

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) state <= ST_INIT;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_INIT: state_nxt = ST_T0;
         ST_HALT: state_nxt = ST_HALT;
         default: if (bus.RUN) begin
            if (state == ST_T2 && bus.OPCODE == OP_HLT)
               state_nxt = ST_HALT;
            else if (state == ST_T4)
               state_nxt = ST_T0;
`ifdef SEQ_EARLY_END_EN
            else if (state == last_step(bus.OPCODE))
               state_nxt = ST_T0;
`endif
            else
               state_nxt = state + 3'd1;  // unused code 7 wraps to INIT
         end
      endcase
   end

   seq_decode u_decode (
      .state  (state),
      .opcode (bus.OPCODE),
      .cf     (bus.CF),
      .zf     (bus.ZF),
      .run    (bus.RUN),
      .ctrl   (ctrl)
   );

   assign bus.CLR = ctrl.clr;
   assign bus.CE  = ctrl.ce;
   assign bus.SU  = ctrl.su;
   assign bus.AIn = ctrl.ai;
   assign bus.BIn = ctrl.bi;
   assign bus.OIn = ctrl.oi;
   assign bus.IIn = ctrl.ii;
   assign bus.FIn = ctrl.fi;
   assign bus.MIn = ctrl.mi;
   assign bus.RI  = ctrl.ri;
   assign bus.Jn  = ~ctrl.j;
   assign bus.DOn = 1'b1;
   assign bus.AOn = ~ctrl.aout;
   assign bus.BOn = ~ctrl.bout;
   assign bus.IOn = ~ctrl.iout;
   assign bus.COn = ~ctrl.cout;
   assign bus.EOn = ~ctrl.eout;
   assign bus.ROn = ~ctrl.rout;
   assign bus.NOn = ~ctrl.nout;
   assign bus.HLT = ctrl.hlt;

endmodule

// File: tb/tb_sequencer.sv
// Directed bench for sequencer; expectations follow SEQ_EARLY_END_EN when defined.
module tb_sequencer;

   localparam logic [19:0] M_CLR = 20'h1 << 19;
   localparam logic [19:0] M_CE  = 20'h1 << 18;
   localparam logic [19:0] M_SU  = 20'h1 << 17;
   localparam logic [19:0] M_AI  = 20'h1 << 16;
   localparam logic [19:0] M_BI  = 20'h1 << 15;
   localparam logic [19:0] M_OI  = 20'h1 << 14;
   localparam logic [19:0] M_II  = 20'h1 << 13;
   localparam logic [19:0] M_FI  = 20'h1 << 12;
   localparam logic [19:0] M_MI  = 20'h1 << 11;
   localparam logic [19:0] M_RI  = 20'h1 << 10;
   localparam logic [19:0] M_J   = 20'h1 << 9;
   localparam logic [19:0] M_AO  = 20'h1 << 7;
   localparam logic [19:0] M_IO  = 20'h1 << 5;
   localparam logic [19:0] M_CO  = 20'h1 << 4;
   localparam logic [19:0] M_EO  = 20'h1 << 3;
   localparam logic [19:0] M_RO  = 20'h1 << 2;
   localparam logic [19:0] M_NO  = 20'h1 << 1;
   localparam logic [19:0] M_HLT = 20'h1;
   // Inactive levels: enables 0, active-low selects 1, HLT 0. XOR a mask to assert.
   localparam logic [19:0] IDLE  = 20'h003FE;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   passed = 0;

   seq_if bus ();

   sequencer dut (
      .CLK    (clk),
      .RESETn (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   logic [19:0] obs;
   assign obs = {bus.CLR, bus.CE, bus.SU, bus.AIn, bus.BIn, bus.OIn, bus.IIn, bus.FIn,
                 bus.MIn, bus.RI, bus.Jn, bus.DOn, bus.AOn, bus.BOn, bus.IOn, bus.COn,
                 bus.EOn, bus.ROn, bus.NOn, bus.HLT};

   task automatic chk(input string tag, input logic [19:0] mask);
      total++;
      assert (obs === (IDLE ^ mask)) passed++;
      else $error("FAIL %s: observed=%h expected=%h", tag, obs, IDLE ^ mask);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Step from the instruction's last active step to the next T0.
   task automatic to_t0(input int last);
`ifndef SEQ_EARLY_END_EN
      for (int s = last + 1; s <= 4; s++) begin
         tick();
         chk($sformatf("T%0d_empty", s), '0);
      end
`endif
      tick();
      chk("T0_next", M_CO | M_MI);
   endtask

   task automatic fetch(input logic [3:0] op);
      bus.OPCODE = op;
      tick(); chk("T1", M_RO | M_II | M_CE);
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      bus.RUN = 1'b1;
      bus.OPCODE = 4'h0;
      bus.CF = 1'b0;
      bus.ZF = 1'b0;
      #2 chk("reset", M_CLR);
      #10 rst_n = 1'b1;
      #1 chk("init", M_CLR);
      tick(); chk("T0", M_CO | M_MI);

      // ADD, then SUB
      fetch(4'h2);
      chk("add_T2", M_IO | M_MI);
      tick(); chk("add_T3", M_RO | M_BI);
      tick(); chk("add_T4", M_EO | M_AI | M_FI);
      tick(); chk("add_T0", M_CO | M_MI);
      fetch(4'h3);
      chk("sub_T2", M_IO | M_MI);
      tick(); chk("sub_T3", M_RO | M_BI);
      tick(); chk("sub_T4", M_EO | M_AI | M_FI | M_SU);
      tick(); chk("sub_T0", M_CO | M_MI);

      // LDA with RUN dropped in T3
      fetch(4'h1);
      chk("lda_T2", M_IO | M_MI);
      tick(); chk("lda_T3", M_RO | M_AI);
      bus.RUN = 1'b0;
      #1 chk("lda_frozen", '0);
      for (int i = 0; i < 4; i++) begin
         tick(); chk("lda_frozen", '0);
      end
      bus.RUN = 1'b1;
      #1 chk("lda_T3_resume", M_RO | M_AI);
      to_t0(3);

      // JC both ways, JZ both ways
      bus.CF = 1'b0;
      fetch(4'h7);
      chk("jc_cf0", M_IO);
      to_t0(2);
      bus.CF = 1'b1;
      fetch(4'h7);
      chk("jc_cf1", M_IO | M_J);
      to_t0(2);
      bus.ZF = 1'b1;
      fetch(4'h8);
      chk("jz_zf1", M_IO | M_J);
      to_t0(2);
      bus.ZF = 1'b0;
      fetch(4'h8);
      chk("jz_zf0", M_IO);
      to_t0(2);

      // Remaining opcodes
      fetch(4'h5); chk("ldi_T2", M_IO | M_AI); to_t0(2);
      fetch(4'h6); chk("jmp_T2", M_IO | M_J);  to_t0(2);
      fetch(4'h9); chk("in_T2",  M_NO | M_AI); to_t0(2);
      fetch(4'hE); chk("out_T2", M_AO | M_OI); to_t0(2);
      fetch(4'h4);
      chk("sta_T2", M_IO | M_MI);
      tick(); chk("sta_T3", M_AO | M_RI);
      to_t0(3);
      fetch(4'hB); chk("nop_T2", '0); to_t0(2);

      // Reset mid-instruction
      fetch(4'h2);
      chk("add2_T2", M_IO | M_MI);
      rst_n = 1'b0;
      #1 chk("reset_mid", M_CLR);
      #2 rst_n = 1'b1;
      tick(); chk("T0_after_mid_reset", M_CO | M_MI);

      // HLT
      fetch(4'hF);
      chk("hlt_T2", '0);
      for (int i = 0; i < 20; i++) begin
         tick(); chk("halted", M_HLT);
      end
      bus.RUN = 1'b0;
      tick(); chk("halted_run0", M_HLT);
      rst_n = 1'b0;
      #1 chk("reset_halt", M_CLR);
      #2 rst_n = 1'b1;
      #1 chk("init_after_halt", M_CLR);
      tick(); chk("T0_run0", '0);
      bus.RUN = 1'b1;
      #1 chk("T0_run1", M_CO | M_MI);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
